// File: rtl/mcp4921_audio.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mcp4921_audio
//  Description : SPI write-frame transmitter for an MCP4921 12-bit DAC.
//                Accepts one sample per valid/ready handshake, shifts out a
//                16-bit frame MSB first on a divided SCLK, then pulses LDAC_n
//                so the DAC output updates at a well-defined instant.
//  Revision    : 1.0  initial release
// ============================================================================
module mcp4921_audio #(
    parameter int unsigned SCLK_DIV = 4,     // CLK50 cycles per SCLK half-period
    parameter bit          GAIN_1X  = 1'b1   // GA_n bit: 1 = 1x, 0 = 2x
) (
    input  logic        CLK50,
    input  logic        reset_n,
    input  logic [11:0] dac_in,
    input  logic        dac_valid,
    output logic        dac_ready,
    output logic        SPI_OUT,
    output logic        SCLK,
    output logic        CS_n,
    output logic        LDAC_n
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_LATCH = 3'd4
    } state_t;

    localparam int         CW         = 8;
    localparam logic [CW-1:0] C_DIV_LAST = CW'(SCLK_DIV - 1);

    state_t          state_q,  state_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [3:0]      bit_q,    bit_d;     // falling edges already issued
    logic [14:0]     shreg_q,  shreg_d;   // bits still to be presented
    logic            spi_q,    spi_d;
    logic            sclk_q,   sclk_d;
    logic            csn_q,    csn_d;
    logic            ldacn_q,  ldacn_d;
    logic            ready_q,  ready_d;

    logic [15:0]     w_frame;
    logic            w_tick;

    // Command nibble: DAC A, unbuffered, selected gain, output active
    assign w_frame = {1'b0, 1'b0, GAIN_1X, 1'b1, dac_in};
    assign w_tick  = (cnt_q == C_DIV_LAST);

    // State and datapath registers; every output comes straight from a flop
    always_ff @(posedge CLK50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            spi_q   <= 1'b0;
            sclk_q  <= 1'b0;
            csn_q   <= 1'b1;
            ldacn_q <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            spi_q   <= spi_d;
            sclk_q  <= sclk_d;
            csn_q   <= csn_d;
            ldacn_q <= ldacn_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic: the divider restarts on each state entry and SCLK toggle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        spi_d   = spi_q;
        sclk_d  = sclk_q;
        csn_d   = csn_q;
        ldacn_d = ldacn_q;
        ready_d = ready_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (dac_valid && ready_q) begin
                    state_d = ST_SETUP;
                    shreg_d = w_frame[14:0];
                    spi_d   = w_frame[15];
                    csn_d   = 1'b0;
                    ready_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    bit_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            state_d = ST_GAP;
                            csn_d   = 1'b1;
                            spi_d   = 1'b0;
                        end else begin
                            spi_d   = shreg_q[14];
                            shreg_d = {shreg_q[13:0], 1'b0};
                            bit_d   = bit_q + 4'd1;
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    state_d = ST_LATCH;
                    cnt_d   = '0;
                    ldacn_d = 1'b0;
                end
            end
            ST_LATCH: begin
                if (w_tick) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ldacn_d = 1'b1;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign dac_ready = ready_q;
    assign SPI_OUT   = spi_q;
    assign SCLK      = sclk_q;
    assign CS_n      = csn_q;
    assign LDAC_n    = ldacn_q;

endmodule
`default_nettype wire

// File: tb/tb_mcp4921_audio.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mcp4921_audio
//  Description : Self-checking bench for mcp4921_audio. Three instances
//                (D=4 gain 1x, D=4 gain 2x, D=1 gain 1x) share one clock and
//                reset; accepted samples are queued as expected frames and a
//                monitor decodes the SPI bus and event timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mcp4921_audio;

    localparam int NI          = 3;
    localparam int DV [NI]     = '{4, 4, 1};
    localparam bit GV [NI]     = '{1'b1, 1'b0, 1'b1};

    logic        CLK50 = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] din   [NI];
    logic        valid [NI];
    logic        ready [NI];
    logic        spi   [NI];
    logic        sclk  [NI];
    logic        csn   [NI];
    logic        ldacn [NI];

    always #10 CLK50 = ~CLK50;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mcp4921_audio #(
            .SCLK_DIV (DV[g]),
            .GAIN_1X  (GV[g])
        ) u_dut (
            .CLK50     (CLK50),
            .reset_n   (reset_n),
            .dac_in    (din[g]),
            .dac_valid (valid[g]),
            .dac_ready (ready[g]),
            .SPI_OUT   (spi[g]),
            .SCLK      (sclk[g]),
            .CS_n      (csn[g]),
            .LDAC_n    (ldacn[g])
        );
    end

    // Scoreboard and bookkeeping
    logic [15:0] exp_q [NI][$];
    int  cyc   = 0;
    int  tests = 0;
    int  fails = 0;
    bit  done  = 1'b0;
    bit  tmo   = 1'b0;
    bit  b2b   = 1'b0;

    // Reference model: every accepted sample becomes one expected frame word
    always @(posedge CLK50) begin
        cyc++;
        for (int i = 0; i < NI; i++)
            if (reset_n && valid[i] && ready[i])
                exp_q[i].push_back({1'b0, 1'b0, GV[i], 1'b1, din[i]});
    end

    task automatic chk(input string nm, input int i, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s[%0d] at cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, i, cyc, act, act, exp, exp);
        end
    endtask

    // Monitor state
    bit          pr_rdy [NI];
    bit          pr_sclk[NI];
    bit          pr_cs  [NI];
    bit          pr_ld  [NI];
    bit          have_last[NI];
    bit          cs_seen[NI];
    logic [15:0] rx     [NI];
    int          nb     [NI];
    int          k      [NI];
    int          last_k [NI];
    int          cs_rise[NI];
    int          ld_fall[NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            pr_rdy[i] = 1'b1; pr_sclk[i] = 1'b0; pr_cs[i] = 1'b1; pr_ld[i] = 1'b1;
            have_last[i] = 1'b0; cs_seen[i] = 1'b0; rx[i] = '0; nb[i] = 0;
            k[i] = 0; last_k[i] = 0; cs_rise[i] = 0; ld_fall[i] = 0;
        end
    end

    // Monitor: decodes frames and checks event timing on the falling clock edge
    always @(negedge CLK50) begin
        if (!reset_n) begin
            for (int i = 0; i < NI; i++) begin
                chk("rst_sclk",  i, sclk[i],  0);
                chk("rst_cs_n",  i, csn[i],   1);
                chk("rst_ldac_n",i, ldacn[i], 1);
                chk("rst_spi",   i, spi[i],   0);
                chk("rst_ready", i, ready[i], 1);
                exp_q[i].delete();
                nb[i] = 0; rx[i] = '0; have_last[i] = 1'b0;
                pr_rdy[i] = 1'b1; pr_sclk[i] = 1'b0; pr_cs[i] = 1'b1; pr_ld[i] = 1'b1;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (sclk[i] && !pr_sclk[i]) begin
                    chk("cs_low_at_rise", i, csn[i], 0);
                    rx[i] = {rx[i][14:0], spi[i]};
                    nb[i]++;
                end
                if (pr_rdy[i] && !ready[i]) begin
                    k[i] = cyc; nb[i] = 0; rx[i] = '0;
                    chk("cs_fall_at_accept", i, csn[i], 0);
                    if (cs_seen[i])
                        chk("cs_high_gap_ge_D", i, longint'((cyc - cs_rise[i]) >= DV[i]), 1);
                    if (b2b && have_last[i])
                        chk("b2b_period", i, cyc - last_k[i], 34 * DV[i] + 1);
                    last_k[i] = cyc;
                    have_last[i] = b2b;
                end
                if (!pr_cs[i] && csn[i]) begin
                    cs_rise[i] = cyc; cs_seen[i] = 1'b1;
                    chk("bit_count", i, nb[i], 16);
                    chk("cs_low_cycles", i, cyc - k[i], 32 * DV[i]);
                    chk("frame_expected", i, longint'(exp_q[i].size() > 0), 1);
                    if (exp_q[i].size() > 0)
                        chk("frame_data", i, rx[i], exp_q[i].pop_front());
                end
                if (pr_ld[i] && !ldacn[i]) begin
                    ld_fall[i] = cyc;
                    chk("ldac_delay", i, cyc - cs_rise[i], DV[i]);
                end
                if (!pr_ld[i] && ldacn[i])
                    chk("ldac_width", i, cyc - ld_fall[i], DV[i]);
                if (!pr_rdy[i] && ready[i])
                    chk("ready_return", i, cyc - k[i], 34 * DV[i]);
                pr_rdy[i] = ready[i]; pr_sclk[i] = sclk[i];
                pr_cs[i]  = csn[i];   pr_ld[i]   = ldacn[i];
            end
        end
        if (done) begin
            for (int i = 0; i < NI; i++)
                chk("queue_drained", i, exp_q[i].size(), 0);
            chk("no_timeout", 0, tmo, 0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic wait_idle(input int i);
        int n = 0;
        @(negedge CLK50);
        while (!ready[i] && n < 600) begin
            @(negedge CLK50);
            n++;
        end
        if (n >= 600) tmo = 1'b1;
    endtask

    task automatic send(input int i, input logic [11:0] v);
        wait_idle(i);
        din[i]   = v;
        valid[i] = 1'b1;
        @(negedge CLK50);
        valid[i] = 1'b0;
    endtask

    // Stimulus
    initial begin
        logic [11:0] v;
        for (int i = 0; i < NI; i++) begin
            din[i] = '0; valid[i] = 1'b0;
        end
        repeat (3) @(posedge CLK50);
        #2 reset_n = 1'b1;

        // Directed: reference sample and extremes on every configuration
        fork
            send(0, 12'hA5C);
            send(1, 12'hFFF);
            send(2, 12'h123);
        join
        send(0, 12'h000);
        send(0, 12'hFFF);
        send(1, 12'h000);
        send(2, 12'hFFF);

        // Random samples on all instances concurrently
        for (int r = 0; r < 6; r++) begin
            fork
                send(0, 12'($urandom));
                send(1, 12'($urandom));
                send(2, 12'($urandom));
            join
        end
        for (int i = 0; i < NI; i++) wait_idle(i);

        // Back-to-back: valid held high, value incremented after each accept
        b2b = 1'b1;
        din[0] = 12'($urandom);
        valid[0] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            int n = 0;
            while (!ready[0] && n < 600) begin
                @(negedge CLK50);
                n++;
            end
            if (n >= 600) tmo = 1'b1;
            @(negedge CLK50);
            din[0] = din[0] + 12'd1;
        end
        valid[0] = 1'b0;
        wait_idle(0);
        b2b = 1'b0;

        // Valid pulsed and data changed mid-frame: must be ignored
        v = 12'($urandom);
        send(0, v);
        repeat (40) @(negedge CLK50);
        din[0] = ~v;
        valid[0] = 1'b1;
        @(negedge CLK50);
        valid[0] = 1'b0;
        din[0] = 12'($urandom);
        wait_idle(0);

        // Reset during bit 7 of the shift phase, then a clean frame
        send(0, 12'($urandom));
        repeat (61) @(negedge CLK50);
        @(posedge CLK50);
        #3 reset_n = 1'b0;
        repeat (2) @(posedge CLK50);
        #2 reset_n = 1'b1;
        send(0, 12'($urandom));

        fork
            send(0, 12'($urandom));
            send(1, 12'($urandom));
            send(2, 12'($urandom));
        join
        for (int i = 0; i < NI; i++) wait_idle(i);
        repeat (5) @(negedge CLK50);
        @(posedge CLK50);
        done = 1'b1;
    end

    // Global watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
